// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with start/busy/done handshake.
// Ports: clk, rst_n, start, sel, EA, EB -> busy, done, res, hi, flag, div_zero, illegal.
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] EA,
    input  logic [WIDTH-1:0] EB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] hi,
    output logic             flag,
    output logic             div_zero,
    output logic             illegal
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic               is_div;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;
    logic [SHW-1:0]     cnt;

    logic [WIDTH-1:0]   c_res;
    logic [WIDTH-1:0]   c_hi;
    logic               c_dz;
    logic               iter;
    logic [2*WIDTH-1:0] p_nxt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rs;
    logic [WIDTH:0]     df;

    // Single-cycle results, including the divide-by-zero and illegal cases.
    always_comb begin
        c_res = '0;
        c_hi  = '0;
        c_dz  = 1'b0;
        case (sel)
            4'd0: c_res = EA + EB;
            4'd1: c_res = EA - EB;
            4'd2: c_res = EA & EB;
            4'd3: c_res = EA | EB;
            4'd4: c_res = {{(WIDTH-1){1'b0}}, EA < EB};
            4'd5: c_res = EA << EB[SHW-1:0];
            4'd7: begin
                c_res = '1;
                c_hi  = EA;
                c_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    assign iter = (sel == 4'd6) || (sel == 4'd7 && EB != '0);

    // p holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; m is the other operand.
    always_comb begin
        sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        rs    = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        df    = rs - {1'b0, m};
        p_nxt = '0;
        if (!is_div)
            p_nxt = {sum, p[WIDTH-1:1]};
        else if (!df[WIDTH])
            p_nxt = {df[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        else
            p_nxt = {rs[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            m        <= '0;
            p        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res      <= '0;
            hi       <= '0;
            flag     <= 1'b1;
            div_zero <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (iter) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            is_div <= sel[0];
                            m      <= sel[0] ? EB : EA;
                            p      <= {{WIDTH{1'b0}}, sel[0] ? EA : EB};
                        end else begin
                            done     <= 1'b1;
                            res      <= c_res;
                            hi       <= c_hi;
                            flag     <= (c_res == '0);
                            div_zero <= c_dz;
                            illegal  <= sel[3];
                        end
                    end
                end
                RUN: begin
                    p   <= p_nxt;
                    cnt <= cnt + 1'b1;
                    // busy drops one cycle ahead of done so the
                    // stall releases as the result lands.
                    if (cnt == SHW'(WIDTH-2))
                        busy <= 1'b0;
                    if (cnt == SHW'(WIDTH-1)) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        res      <= p_nxt[WIDTH-1:0];
                        hi       <= p_nxt[2*WIDTH-1:WIDTH];
                        flag     <= (p_nxt[WIDTH-1:0] == '0);
                        div_zero <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
